// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: round-robin arbiter for the single register-file write port with a 16-entry clear sequencer.
module rf_write_ctrl #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        v0,
  input  logic [15:0] d0,
  input  logic [3:0]  dst0,
  output logic        rdy0,
  input  logic        v1,
  input  logic [15:0] d1,
  input  logic [3:0]  dst1,
  output logic        rdy1,
  output logic        load_en,
  output logic [15:0] d,
  output logic [3:0]  dest_sel,
  output logic        busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  state_t state, state_n;
  logic [3:0] cnt;
  logic       last_grant;
  logic       run_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RST_STATE;
    else     state <= state_n;
  always_comb begin
    state_n = (state == CLEAR) ? ((cnt == 4'd15) ? RUN : CLEAR) : (clr ? CLEAR : RUN);
  end
  // last_grant=1 means requester 1 won most recently, so requester 0 wins the next tie
  assign run_ok   = (state == RUN) && !clr;
  assign rdy0     = run_ok && v0 && (!v1 || last_grant);
  assign rdy1     = run_ok && v1 && (!v0 || !last_grant);
  assign busy     = (state == CLEAR);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      load_en    <= 1'b0;
      d          <= '0;
      dest_sel   <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else if (state == CLEAR) begin
      load_en  <= 1'b1;
      d        <= '0;
      dest_sel <= cnt;
      cnt      <= cnt + 4'd1;
    end else begin
      load_en <= rdy0 || rdy1;
      if (rdy0) begin
        d          <= d0;
        dest_sel   <= dst0;
        last_grant <= 1'b0;
      end else if (rdy1) begin
        d          <= d1;
        dest_sel   <= dst1;
        last_grant <= 1'b1;
      end
      if (clr) cnt <= '0;
    end
endmodule
